// File: rtl/sc_point_pkg.sv
// Shared constants for the point datapath: shift codes, default matrix size,
// edge-flag bit positions and a saturating move counter helper.
package sc_point_pkg;

  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  // Bit positions inside the 3-bit {top, leftmost, rightmost} edge vector
  localparam int EDGE_W     = 3;
  localparam int EDGE_TOP   = 2;
  localparam int EDGE_LEFT  = 1;
  localparam int EDGE_RIGHT = 0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sc_regpoint_falltimer.sv
// Gravity timer: counts 0..FALL_TICKS-1 while enabled, holds when disabled,
// and raises o_tick for the single cycle in which the count wraps to zero.
module sc_regpoint_falltimer #(
  parameter int FALL_TICKS = 25000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = $clog2(FALL_TICKS);
  localparam logic [CW-1:0] LAST = CW'(FALL_TICKS - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = i_enable && (r_count == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
    end
  end

  assign o_tick = w_wrap;

endmodule

// File: rtl/sc_regpoint.sv
// Point position register: executes clear/up/down/shift commands by priority,
// applies gravity drops (deferred by one slot when a command is present).
module sc_regpoint
  import sc_point_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int FALL_TICKS = 25000000
) (
  input  logic                    SC_REGPOINT_CLOCK_50,
  input  logic                    SC_REGPOINT_RESET_InHigh,
  input  logic                    SC_REGPOINT_clear_InLow,
  input  logic                    SC_REGPOINT_load0_InLow,
  input  logic                    SC_REGPOINT_load1_InLow,
  input  logic [1:0]              SC_REGPOINT_shiftselection_In,
  input  logic                    SC_REGPOINT_gravityEnable_InHigh,
  output logic [$clog2(ROWS)-1:0] SC_REGPOINT_row_Out,
  output logic [COLS-1:0]         SC_REGPOINT_column_Out,
  output logic                    SC_REGPOINT_bottomsidecomparator_OutLow,
  output logic [EDGE_W-1:0]       SC_REGPOINT_edge_Out,
  output logic                    SC_REGPOINT_landed_OutHigh,
  output logic [7:0]              SC_REGPOINT_moveCount_Out
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
  localparam logic [COLS-1:0] COL_HOME = {{(COLS-1){1'b0}}, 1'b1} << (COLS / 2);

  logic [RW-1:0]   r_row, w_row_nxt;
  logic [COLS-1:0] r_col, w_col_nxt;
  logic [7:0]      r_moves;
  logic            r_landed, w_land;
  logic            r_pending;
  logic            w_moved, w_tick, w_drop, w_bottom;
  logic            w_clr, w_up, w_dn, w_left, w_right, w_cmd;
  logic            w_en;

  // Commands are one-cycle active-low strobes with no back-pressure: each is
  // sampled on every rising edge and either acted on or dropped that cycle.
  assign w_clr   = ~SC_REGPOINT_clear_InLow;
  assign w_up    = ~SC_REGPOINT_load0_InLow;
  assign w_dn    = ~SC_REGPOINT_load1_InLow;
  assign w_left  = (SC_REGPOINT_shiftselection_In == SHIFT_LEFT);
  assign w_right = (SC_REGPOINT_shiftselection_In == SHIFT_RIGHT);
  assign w_cmd   = w_up | w_dn | w_left | w_right;
  assign w_en    = SC_REGPOINT_gravityEnable_InHigh;
  assign w_bottom = (r_row == ROW_LAST);
  assign w_drop   = w_en && (w_tick || r_pending);

  sc_regpoint_falltimer #(.FALL_TICKS(FALL_TICKS)) u_falltimer (
    .i_clk    (SC_REGPOINT_CLOCK_50),
    .i_rst    (SC_REGPOINT_RESET_InHigh),
    .i_enable (w_en),
    .i_clear  (w_clr),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_moved   = 1'b0;
    w_land    = 1'b0;
    if (w_clr) begin
      w_row_nxt = '0;
      w_col_nxt = COL_HOME;
    end else if (w_up) begin
      if (r_row != '0) begin
        w_row_nxt = r_row - 1'b1;
        w_moved   = 1'b1;
      end
    end else if (w_dn) begin
      if (!w_bottom) begin
        w_row_nxt = r_row + 1'b1;
        w_moved   = 1'b1;
      end
    end else if (w_left) begin
      if (!r_col[COLS-1]) begin
        w_col_nxt = r_col << 1;
        w_moved   = 1'b1;
      end
    end else if (w_right) begin
      if (!r_col[0]) begin
        w_col_nxt = r_col >> 1;
        w_moved   = 1'b1;
      end
    end else if (w_drop) begin
      if (!w_bottom) begin
        w_row_nxt = r_row + 1'b1;
        w_moved   = 1'b1;
      end else begin
        w_land = 1'b1;
      end
    end
  end

  always_ff @(posedge SC_REGPOINT_CLOCK_50) begin
    if (SC_REGPOINT_RESET_InHigh) begin
      r_row     <= '0;
      r_col     <= COL_HOME;
      r_moves   <= '0;
      r_landed  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_landed <= w_land;
      if (w_moved) r_moves <= sat_inc8(r_moves);
      // A tick blocked by a command is remembered; any command-free cycle consumes it
      if (w_clr || !w_en)  r_pending <= 1'b0;
      else if (w_cmd)      r_pending <= r_pending | w_tick;
      else                 r_pending <= 1'b0;
    end
  end

  always_comb begin
    SC_REGPOINT_edge_Out             = '0;
    SC_REGPOINT_edge_Out[EDGE_TOP]   = (r_row == '0);
    SC_REGPOINT_edge_Out[EDGE_LEFT]  = r_col[COLS-1];
    SC_REGPOINT_edge_Out[EDGE_RIGHT] = r_col[0];
  end

  assign SC_REGPOINT_row_Out                     = r_row;
  assign SC_REGPOINT_column_Out                  = r_col;
  assign SC_REGPOINT_bottomsidecomparator_OutLow = ~w_bottom;
  assign SC_REGPOINT_landed_OutHigh              = r_landed;
  assign SC_REGPOINT_moveCount_Out               = r_moves;

endmodule

// File: tb/tb_sc_regpoint.sv
// Bench for sc_regpoint: directed scenarios plus random commands, all cycles
// scored against an index/counter-level model through an expected queue.
module tb_sc_regpoint;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int FT   = 4;
  localparam int W    = 24;

  logic       clk;
  logic       rst;
  logic       clear_n, load0_n, load1_n;
  logic [1:0] shsel;
  logic       gen;
  logic [2:0] row_o;
  logic [7:0] col_o;
  logic       bottom_o;
  logic [2:0] edge_o;
  logic       landed_o;
  logic [7:0] cnt_o;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;
  int cyc;

  // reference model state
  int  m_row, m_col, m_cnt, m_t;
  bit  m_pend, m_land;

  sc_regpoint #(.ROWS(ROWS), .COLS(COLS), .FALL_TICKS(FT)) dut (
    .SC_REGPOINT_CLOCK_50                    (clk),
    .SC_REGPOINT_RESET_InHigh                (rst),
    .SC_REGPOINT_clear_InLow                 (clear_n),
    .SC_REGPOINT_load0_InLow                 (load0_n),
    .SC_REGPOINT_load1_InLow                 (load1_n),
    .SC_REGPOINT_shiftselection_In           (shsel),
    .SC_REGPOINT_gravityEnable_InHigh        (gen),
    .SC_REGPOINT_row_Out                     (row_o),
    .SC_REGPOINT_column_Out                  (col_o),
    .SC_REGPOINT_bottomsidecomparator_OutLow (bottom_o),
    .SC_REGPOINT_edge_Out                    (edge_o),
    .SC_REGPOINT_landed_OutHigh              (landed_o),
    .SC_REGPOINT_moveCount_Out               (cnt_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_pack();
    logic [7:0] col;
    logic [2:0] edg;
    col = 8'd1 << m_col;
    edg = {m_row == 0, m_col == COLS - 1, m_col == 0};
    return {3'(m_row), col, (m_row == ROWS - 1) ? 1'b0 : 1'b1, edg, m_land, 8'(m_cnt)};
  endfunction

  function automatic void model_reset();
    m_row = 0; m_col = COLS / 2; m_cnt = 0; m_t = 0; m_pend = 0; m_land = 0;
  endfunction

  function automatic void model_step(bit r, bit clr, bit up, bit dn, logic [1:0] sh, bit en);
    bit tick, cmd, lf, rt;
    if (r) begin
      model_reset();
      return;
    end
    lf   = (sh == 2'b01);
    rt   = (sh == 2'b10);
    cmd  = up || dn || lf || rt;
    tick = en && (m_t == FT - 1);
    if (en) m_t = (m_t == FT - 1) ? 0 : m_t + 1;
    m_land = 0;
    if (clr) begin
      m_row = 0; m_col = COLS / 2; m_t = 0;
    end else if (up) begin
      if (m_row > 0) begin m_row--; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
    end else if (dn) begin
      if (m_row < ROWS - 1) begin m_row++; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
    end else if (lf) begin
      if (m_col < COLS - 1) begin m_col++; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
    end else if (rt) begin
      if (m_col > 0) begin m_col--; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
    end else if (en && (tick || m_pend)) begin
      if (m_row < ROWS - 1) begin m_row++; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
      else m_land = 1;
    end
    if (clr || !en) m_pend = 0;
    else if (cmd)   m_pend = m_pend || tick;
    else            m_pend = 0;
  endfunction

  // driver: apply one cycle of inputs (command args active-high), score it
  task automatic drive(input bit r, input bit clr, input bit up, input bit dn,
                       input logic [1:0] sh, input bit en);
    rst     = r;
    clear_n = ~clr;
    load0_n = ~up;
    load1_n = ~dn;
    shsel   = sh;
    gen     = en;
    @(posedge clk);
    model_step(r, clr, up, dn, sh, en);
    exp_q.push_back(model_pack());
    #1;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 2'b11, en);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {row_o, col_o, bottom_o, edge_o, landed_o, cnt_o};
      checks++;
      cyc++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard cycle=%0d act(row=%0d col=%b bot=%b edge=%b land=%b cnt=%0d) exp(row=%0d col=%b bot=%b edge=%b land=%b cnt=%0d)",
                 cyc, a[23:21], a[20:13], a[12], a[11:9], a[8], a[7:0],
                 e[23:21], e[20:13], e[12], e[11:9], e[8], e[7:0]);
      end
    end
  end

  initial begin
    int lc;
    checks = 0; failures = 0; cyc = 0;
    model_reset();

    // reset then idle with gravity off
    drive(1, 0, 0, 0, 2'b11, 0);
    drive(1, 0, 0, 0, 2'b11, 0);
    idle(20, 0);
    chk("idle_row", 8'(row_o), 8'd0);
    chk("idle_col", col_o, 8'b00010000);
    chk("idle_bottom", 8'(bottom_o), 8'd1);
    chk("idle_edge", 8'(edge_o), 8'b100);
    chk("idle_cnt", cnt_o, 8'd0);

    // down pulses into the bottom
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 2'b11, 0);
    chk("down3_row", 8'(row_o), 8'd3);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 2'b11, 0);
    chk("down12_row", 8'(row_o), 8'd7);
    chk("down12_bottom", 8'(bottom_o), 8'd0);
    chk("down12_cnt", cnt_o, 8'd7);

    // left saturation then clear
    drive(1, 0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 2'b01, 0);
    chk("left_col", col_o, 8'b10000000);
    chk("left_edge1", 8'(edge_o[1]), 8'd1);
    chk("left_cnt", cnt_o, 8'd3);
    drive(0, 1, 0, 0, 2'b11, 0);
    chk("clr_row", 8'(row_o), 8'd0);
    chk("clr_col", col_o, 8'b00010000);
    chk("clr_cnt", cnt_o, 8'd3);

    // landing at the bottom
    drive(1, 0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 1, 2'b11, 0);
    lc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, 2'b11, 1);
      if (landed_o) lc++;
    end
    chk("land_pulses", 8'(lc), 8'd3);
    chk("land_row", 8'(row_o), 8'd7);
    chk("land_cnt", cnt_o, 8'd7);

    // down on the tick cycle defers the drop by one cycle
    drive(1, 0, 0, 0, 2'b11, 0);
    drive(0, 0, 0, 1, 2'b11, 1);
    drive(0, 0, 0, 1, 2'b11, 1);
    drive(0, 0, 0, 0, 2'b11, 1);
    drive(0, 0, 0, 1, 2'b11, 1);
    chk("tickcmd_row", 8'(row_o), 8'd3);
    drive(0, 0, 0, 0, 2'b11, 1);
    chk("pend_row", 8'(row_o), 8'd4);
    idle(2, 1);
    chk("nodouble_row", 8'(row_o), 8'd4);

    // clear beats everything; reset mid-count with a pending drop
    drive(1, 0, 0, 0, 2'b11, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 2'b11, 0);
    drive(0, 1, 1, 1, 2'b01, 0);
    chk("prio_row", 8'(row_o), 8'd0);
    chk("prio_col", col_o, 8'b00010000);
    chk("prio_cnt", cnt_o, 8'd5);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 2'b11, 1);
    drive(1, 0, 0, 0, 2'b11, 1);
    chk("rst_row", 8'(row_o), 8'd0);
    chk("rst_col", col_o, 8'b00010000);
    chk("rst_cnt", cnt_o, 8'd0);
    drive(0, 0, 0, 0, 2'b11, 1);
    chk("rst_nopend_row", 8'(row_o), 8'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] sh;
      sh = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            sh, $urandom_range(0, 9) != 0);
    end

    // drain with a bound
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
